// File: rtl/dbg_uart_bridge_if.sv
// Debug port bus between the UART bridge (master) and the soc (slave).
// Ports: dbg_addr, dbg_din, dbg_wr_en, dbg_req (master->slave); dbg_dout, dbg_ack (slave->master).
interface dbg_uart_bridge_if;
    logic [1:0]  dbg_addr;
    logic [31:0] dbg_din;
    logic [31:0] dbg_dout;
    logic        dbg_wr_en;
    logic        dbg_req;
    logic        dbg_ack;

    modport master (
        output dbg_addr, dbg_din, dbg_wr_en, dbg_req,
        input  dbg_dout, dbg_ack
    );

    modport slave (
        input  dbg_addr, dbg_din, dbg_wr_en, dbg_req,
        output dbg_dout, dbg_ack
    );
endinterface

// File: rtl/dbg_uart_bridge.sv
// UART byte stream -> soc debug transactions, replies sent back to the UART transmitter.
// Ports: clk, rst (sync, active high); rx_data/rx_valid from UART rx; tx_data/tx_valid/tx_ready
// to UART tx; dbg (debug bus master); rx_overrun sticky flag. Optional: DBG_BRIDGE_TIMEOUT_EN.
module dbg_uart_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    dbg_uart_bridge_if.master dbg,
    output logic              rx_overrun
);
    typedef enum logic [2:0] {IDLE, WDATA, REQ, WAIT_ACK, RESP} state_t;

    state_t      state;
    logic [1:0]  cmd_addr;
    logic        cmd_wr;
    logic [1:0]  wcnt;
    logic [23:0] resp_sr;
    logic [2:0]  resp_left;
    logic        busy;
`ifdef DBG_BRIDGE_TIMEOUT_EN
    logic [31:0] tcnt;
`endif

    always_comb begin
        busy = (state != IDLE) && (state != WDATA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tx_data       <= 8'h00;
            tx_valid      <= 1'b0;
            dbg.dbg_addr  <= 2'd0;
            dbg.dbg_din   <= 32'd0;
            dbg.dbg_wr_en <= 1'b0;
            dbg.dbg_req   <= 1'b0;
            rx_overrun    <= 1'b0;
            cmd_addr      <= 2'd0;
            cmd_wr        <= 1'b0;
            wcnt          <= 2'd0;
            resp_sr       <= 24'd0;
            resp_left     <= 3'd0;
`ifdef DBG_BRIDGE_TIMEOUT_EN
            tcnt          <= 32'd0;
`endif
        end else begin
            // Bytes arriving while a request or reply is in flight are lost.
            if (rx_valid && busy) begin
                rx_overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        cmd_addr <= rx_data[1:0];
                        cmd_wr   <= rx_data[7];
                        if (rx_data[6:2] != 5'd0) begin
                            tx_data   <= NAK_BYTE;
                            tx_valid  <= 1'b1;
                            resp_left <= 3'd1;
                            state     <= RESP;
                        end else if (rx_data[7]) begin
                            wcnt  <= 2'd0;
                            state <= WDATA;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                WDATA: begin
                    if (rx_valid) begin
                        // Little-endian: after four shifts the first byte sits in [7:0].
                        dbg.dbg_din <= {rx_data, dbg.dbg_din[31:8]};
                        wcnt        <= wcnt + 2'd1;
                        if (wcnt == 2'd3) begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    dbg.dbg_req   <= 1'b1;
                    dbg.dbg_addr  <= cmd_addr;
                    dbg.dbg_wr_en <= cmd_wr;
`ifdef DBG_BRIDGE_TIMEOUT_EN
                    tcnt          <= 32'd0;
`endif
                    state         <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    // dbg_req is already high in every WAIT_ACK cycle.
                    if (dbg.dbg_ack) begin
                        dbg.dbg_req <= 1'b0;
                        tx_valid    <= 1'b1;
                        state       <= RESP;
                        if (cmd_wr) begin
                            tx_data   <= ACK_BYTE;
                            resp_left <= 3'd1;
                        end else begin
                            tx_data   <= dbg.dbg_dout[7:0];
                            resp_sr   <= dbg.dbg_dout[31:8];
                            resp_left <= 3'd4;
                        end
                    end
`ifdef DBG_BRIDGE_TIMEOUT_EN
                    else if (tcnt == TIMEOUT_CYCLES - 1) begin
                        dbg.dbg_req <= 1'b0;
                        tx_data     <= NAK_BYTE;
                        tx_valid    <= 1'b1;
                        resp_left   <= 3'd1;
                        state       <= RESP;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
`endif
                end
                RESP: begin
                    if (tx_valid && tx_ready) begin
                        if (resp_left == 3'd1) begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            tx_data   <= resp_sr[7:0];
                            resp_sr   <= {8'h00, resp_sr[23:8]};
                            resp_left <= resp_left - 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dbg_uart_bridge.sv
// Self-checking bench for dbg_uart_bridge: directed and randomized transactions
// compared against a byte-level reference model of the command protocol.
module tb_dbg_uart_bridge;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       rx_overrun;

    dbg_uart_bridge_if dbg_bus ();

    dbg_uart_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .dbg        (dbg_bus.master),
        .rx_overrun (rx_overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int req_cycles = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always @(posedge clk) begin
        if (dbg_bus.dbg_req === 1'b1) req_cycles = req_cycles + 1;
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    // Reference: reply bytes follow only from the command and the soc read data.
    task automatic model_resp(input logic [7:0] cmd, input logic [31:0] dout);
        exp_q.delete();
        if ((cmd & 8'h7C) != 8'h00) exp_q.push_back(8'h15);
        else if (cmd >= 8'h80) exp_q.push_back(8'h06);
        else for (int i = 0; i < 4; i++) exp_q.push_back(8'((dout >> (8 * i)) & 32'hFF));
    endtask

    // mode 0: always ready, 1: random ready, 2: ready low 5 cycles per byte
    task automatic collect_tx(input int n, input int mode);
        int guard;
        int stalls;
        logic pv;
        logic pr;
        logic [7:0] pd;
        guard = 0; stalls = 0; pv = 1'b0; pr = 1'b0; pd = 8'h00;
        got_q.delete();
        while (got_q.size() < n && guard < 2000) begin
            if (pv && !pr) begin
                vectors++;
                if (tx_valid !== 1'b1 || tx_data !== pd) begin
                    miscompares++;
                    $display("FAIL tx_hold: got v=%b d=%h required v=1 d=%h", tx_valid, tx_data, pd);
                end
            end
            case (mode)
                0: tx_ready = 1'b1;
                1: tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = (stalls >= 5);
            endcase
            pv = tx_valid; pr = tx_ready; pd = tx_data;
            @(posedge clk); #1;
            if (pv && pr) begin
                got_q.push_back(pd);
                stalls = 0;
            end else if (pv) begin
                stalls++;
            end
            guard++;
        end
        vectors++;
        if (got_q.size() != n) begin
            miscompares++;
            $display("FAIL tx_count: got %0d bytes required %0d", got_q.size(), n);
        end
        vectors++;
        if (tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL tx_drop: got tx_valid=%b required 0", tx_valid);
        end
        tx_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        vectors++;
        if (got_q.size() == n && tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL tx_extra: got tx_valid=%b required 0", tx_valid);
        end
        tx_ready = 1'b0;
    endtask

    task automatic do_txn(input logic [7:0] cmd, input logic [31:0] wdata, input int ack_delay,
                          input logic [31:0] dout, input int mode, input int max_gap, input bit inject);
        logic legal;
        logic held;
        logic [31:0] exp_din;
        int rq0;
        int g;
        legal = (cmd[6:2] == 5'd0);
        exp_din = 0;
        for (int i = 0; i < 4; i++) exp_din = exp_din + ((wdata >> (8 * i)) & 32'hFF) * (32'h1 << (8 * i));
        model_resp(cmd, dout);
        rq0 = req_cycles;
        send_byte(cmd);
        if (legal && cmd[7]) begin
            for (int i = 0; i < 4; i++) begin
                g = $urandom_range(0, max_gap);
                repeat (g) begin @(posedge clk); #1; end
                send_byte(wdata[8 * i +: 8]);
            end
        end
        if (legal) begin
            vectors++;
            if (dbg_bus.dbg_req !== 1'b0) begin
                miscompares++;
                $display("FAIL req_early: got %b required 0", dbg_bus.dbg_req);
            end
            @(posedge clk); #1;
            vectors++;
            if (dbg_bus.dbg_req !== 1'b1) begin
                miscompares++;
                $display("FAIL req_latency: got %b required 1", dbg_bus.dbg_req);
                for (int i = 0; i < 8 && dbg_bus.dbg_req !== 1'b1; i++) begin @(posedge clk); #1; end
                if (dbg_bus.dbg_req !== 1'b1) return;
            end
            vectors++;
            if (dbg_bus.dbg_addr !== cmd[1:0] || dbg_bus.dbg_wr_en !== cmd[7]) begin
                miscompares++;
                $display("FAIL req_fields: got a=%0d w=%b required a=%0d w=%b",
                         dbg_bus.dbg_addr, dbg_bus.dbg_wr_en, cmd[1:0], cmd[7]);
            end
            if (cmd[7]) begin
                vectors++;
                if (dbg_bus.dbg_din !== exp_din) begin
                    miscompares++;
                    $display("FAIL req_din: got %h required %h", dbg_bus.dbg_din, exp_din);
                end
            end
            held = 1'b1;
            for (int d = 0; d < ack_delay; d++) begin
                if (inject && d == 0) begin rx_data = 8'h81; rx_valid = 1'b1; end
                @(posedge clk); #1;
                rx_valid = 1'b0;
                if (dbg_bus.dbg_req !== 1'b1 || dbg_bus.dbg_wr_en !== cmd[7]) held = 1'b0;
            end
            vectors++;
            if (held !== 1'b1) begin
                miscompares++;
                $display("FAIL req_hold: got held=%b required 1", held);
            end
            dbg_bus.dbg_ack = 1'b1;
            dbg_bus.dbg_dout = dout;
            @(posedge clk); #1;
            dbg_bus.dbg_ack = 1'b0;
            dbg_bus.dbg_dout = $urandom;
            vectors++;
            if (dbg_bus.dbg_req !== 1'b0 || tx_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL ack_resp: got req=%b tx_valid=%b required 0 1", dbg_bus.dbg_req, tx_valid);
            end
        end
        collect_tx(exp_q.size(), mode);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL tx_byte%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        if (!legal) begin
            vectors++;
            if (req_cycles != rq0) begin
                miscompares++;
                $display("FAIL illegal_req: got %0d req cycles required 0", req_cycles - rq0);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        vectors++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || rx_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tx: got v=%b d=%h ovr=%b required 0 00 0", tx_valid, tx_data, rx_overrun);
        end
        vectors++;
        if (dbg_bus.dbg_req !== 1'b0 || dbg_bus.dbg_wr_en !== 1'b0 ||
            dbg_bus.dbg_addr !== 2'd0 || dbg_bus.dbg_din !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_dbg: got req=%b we=%b a=%0d din=%h required zeros",
                     dbg_bus.dbg_req, dbg_bus.dbg_wr_en, dbg_bus.dbg_addr, dbg_bus.dbg_din);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read;
        do_txn(8'h02, 32'h0, 3, 32'hDEADBEEF, 0, 0, 1'b0);
    endtask

    task automatic test_write;
        do_txn(8'h81, 32'h12345678, 2, 32'h0, 0, 2, 1'b0);
    endtask

    task automatic test_backpressure;
        do_txn(8'h02, 32'h0, 3, 32'hDEADBEEF, 2, 0, 1'b0);
    endtask

    task automatic test_illegal;
        do_txn(8'h44, 32'h0, 0, 32'h0, 0, 0, 1'b0);
    endtask

    task automatic test_spurious_ack;
        dbg_bus.dbg_ack = 1'b1;
        @(posedge clk); #1;
        dbg_bus.dbg_ack = 1'b0;
        vectors++;
        if (tx_valid !== 1'b0 || dbg_bus.dbg_req !== 1'b0) begin
            miscompares++;
            $display("FAIL spurious_ack: got tx_valid=%b req=%b required 0 0", tx_valid, dbg_bus.dbg_req);
        end
        do_txn(8'h01, 32'h0, 0, 32'h0BADF00D, 1, 0, 1'b0);
    endtask

    task automatic test_random;
        logic [7:0] cmd;
        for (int n = 0; n < 24; n++) begin
            cmd = 8'($urandom);
            if ($urandom_range(0, 3) != 0) cmd[6:2] = 5'd0;
            do_txn(cmd, $urandom, $urandom_range(0, 4), $urandom, $urandom_range(0, 2), 3, 1'b0);
        end
    endtask

    task automatic test_overrun;
        vectors++;
        if (rx_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_pre: got %b required 0", rx_overrun);
        end
        do_txn(8'h03, 32'h0, 3, 32'hCAFE1234, 0, 0, 1'b1);
        vectors++;
        if (rx_overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set: got %b required 1", rx_overrun);
        end
        do_txn(8'h00, 32'h0, 1, 32'h89ABCDEF, 0, 0, 1'b0);
    endtask

    task automatic test_last_handshake_drop;
        int rq0;
        logic bad;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send_byte(8'h02);
        @(posedge clk); #1;
        dbg_bus.dbg_ack = 1'b1;
        dbg_bus.dbg_dout = 32'h11223344;
        @(posedge clk); #1;
        dbg_bus.dbg_ack = 1'b0;
        tx_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rx_data = 8'h02;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        vectors++;
        if (tx_valid !== 1'b0 || rx_overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL last_hs_drop: got tx_valid=%b ovr=%b required 0 1", tx_valid, rx_overrun);
        end
        rq0 = req_cycles;
        bad = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (tx_valid !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (req_cycles != rq0 || bad) begin
            miscompares++;
            $display("FAIL last_hs_quiet: got req cycles=%0d tx=%b required 0 0", req_cycles - rq0, bad);
        end
    endtask

    task automatic test_reset_mid;
        send_byte(8'h01);
        repeat (3) begin @(posedge clk); #1; end
        vectors++;
        if (dbg_bus.dbg_req !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre: got req=%b required 1", dbg_bus.dbg_req);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (dbg_bus.dbg_req !== 1'b0 || tx_valid !== 1'b0 || rx_overrun !== 1'b0 || dbg_bus.dbg_addr !== 2'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got req=%b tx=%b ovr=%b a=%0d required 0 0 0 0",
                     dbg_bus.dbg_req, tx_valid, rx_overrun, dbg_bus.dbg_addr);
        end
        do_txn(8'h02, 32'h0, 2, 32'h5A5AA5A5, 1, 0, 1'b0);
    endtask

`ifdef DBG_BRIDGE_TIMEOUT_EN
    task automatic test_timeout;
        int cnt;
        cnt = 0;
        send_byte(8'h03);
        @(posedge clk); #1;
        while (dbg_bus.dbg_req === 1'b1 && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
        end
        vectors++;
        if (cnt != 16) begin
            miscompares++;
            $display("FAIL timeout_len: got %0d req cycles required 16", cnt);
        end
        dbg_bus.dbg_ack = 1'b1;
        dbg_bus.dbg_dout = 32'h01020304;
        @(posedge clk); #1;
        dbg_bus.dbg_ack = 1'b0;
        model_resp(8'h44, 32'h0);
        collect_tx(1, 0);
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== 8'h15) begin
            miscompares++;
            $display("FAIL timeout_nak: got %0d bytes first %h required 1 byte 15",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        rx_data = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        dbg_bus.dbg_ack = 1'b0;
        dbg_bus.dbg_dout = 32'h0;
        test_reset();
        test_read();
        test_write();
        test_backpressure();
        test_illegal();
        test_spurious_ack();
        test_random();
        test_overrun();
        test_last_handshake_drop();
        test_reset_mid();
`ifdef DBG_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
